beat_sequencer: RTL and testbench
=================================

BEAT_SEQUENCER -- requirements
Module: beat_sequencer

Interface
REQ-001 The block SHALL have parameter BEAT_DIV, default 25000000, giving clk cycles per beat (minimum 2).
REQ-002 The block SHALL have parameter BEAT_LEN, default 64, giving beats per song (range 2..4096).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port play  input  1  one-cycle pulse that starts or resumes playback.
REQ-006 The block SHALL have port pause  input  1  one-cycle pulse that freezes playback.
REQ-007 The block SHALL have port stop  input  1  one-cycle pulse that aborts playback and rewinds.
REQ-008 The block SHALL have port loop_en  input  1  level; 1 = wrap at song end, 0 = finish.
REQ-009 The block SHALL have port ibeatNum  output  12  current beat index, feeding the AM/melody decoders.
REQ-010 The block SHALL have port beat_tick  output  1  one-cycle pulse, high in the first cycle a new ibeatNum is valid.
REQ-011 The block SHALL have port playing  output  1  high while in state PLAY.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse at non-looped song end.

Function
REQ-013 The FSM SHALL have states IDLE, PLAY and PAUSE; all outputs SHALL be registered.
REQ-014 Command priority on one edge SHALL be stop > pause > play; unused commands are ignored.
REQ-015 IDLE: ibeatNum=0, divider=0; play -> PLAY; pause ignored.
REQ-016 PLAY: the divider counts 0..BEAT_DIV-1; on the edge where it equals BEAT_DIV-1 it wraps to 0, ibeatNum advances, and beat_tick is 1 for the following cycle.
REQ-017 The first advance after play from IDLE SHALL occur exactly BEAT_DIV cycles after the edge sampling play.
REQ-018 Song end (advance from BEAT_LEN-1), loop_en=1: ibeatNum -> 0, beat_tick pulses, stay in PLAY, done stays 0.
REQ-019 Song end, loop_en=0: ibeatNum -> 0, done pulses one cycle, beat_tick stays 0, state -> IDLE.
REQ-020 pause in PLAY -> PAUSE; ibeatNum and divider hold; pause sampled on the wrap edge suppresses that advance and the divider holds at BEAT_DIV-1.
REQ-021 play in PAUSE -> PLAY, divider resumes from its held value (no beat lost or duplicated); play in PLAY is ignored.
REQ-022 stop in any state -> IDLE with ibeatNum=0, divider=0, no beat_tick, no done, even on a wrap edge.
REQ-023 ibeatNum SHALL never exceed BEAT_LEN-1; arithmetic is unsigned, divider sized to clog2(BEAT_DIV).

Reset
REQ-024 rst_n low SHALL immediately force IDLE, ibeatNum=0, divider=0, beat_tick=0, playing=0, done=0, regardless of clk.
REQ-025 Reset asserted mid-song SHALL discard position; after release the block waits in IDLE for play.

Configuration
REQ-026 Macro REVERSE_PLAY_EN defined: add input dir (1 bit); dir=1 in PLAY decrements ibeatNum; advance from 0 is song end (wrap to BEAT_LEN-1 if loop_en, else ibeatNum -> 0, done pulse, IDLE); dir may change anytime, taking effect on the next advance.
REQ-027 Macro REVERSE_PLAY_EN undefined: no dir port; counting is up only as in REQ-016..REQ-019.

Verification (BEAT_DIV=4, BEAT_LEN=8)
REQ-028 Reset, play at cycle 0, loop_en=0 -> ibeatNum 1,2,...,7 at cycles 4,8,...,28, beat_tick with each; cycle 32: ibeatNum 0, done=1, playing=0.
REQ-029 loop_en=1, run 40 cycles -> ibeatNum wraps 7->0 at cycle 32 with beat_tick, no done, playing stays 1.
REQ-030 pause at cycle 6 (ibeatNum=1), play at cycle 20 -> ibeatNum=2 at cycle 22, then every 4 cycles.
REQ-031 stop and pause in the same cycle as a wrap at ibeatNum=5 -> IDLE, ibeatNum=0, no beat_tick, no done.
REQ-032 rst_n low between edges at ibeatNum=3 -> outputs zero asynchronously; play after release restarts from beat 0.
REQ-033 REVERSE_PLAY_EN, dir=1, loop_en=1, play -> ibeatNum 7 at cycle 4, 6 at cycle 8; dir=0 mid-song resumes counting up.

Source files
------------

// File: rtl/beat_sequencer.sv
// Beat sequencer: divides clk into beats and steps a song position with play/pause/stop control.
// Optional feature: define REVERSE_PLAY_EN to add a dir input for reverse playback.
module beat_sequencer #(
    parameter int unsigned BEAT_DIV = 25000000,
    parameter int unsigned BEAT_LEN = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        play,
    input  logic        pause,
    input  logic        stop,
`ifdef REVERSE_PLAY_EN
    input  logic        dir,
`endif
    input  logic        loop_en,
    output logic [11:0] ibeatNum,
    output logic        beat_tick,
    output logic        playing,
    output logic        done
);

    localparam int unsigned DIV_W  = $clog2(BEAT_DIV);
    localparam int unsigned BEAT_W = 12;
    localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(BEAT_DIV - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_PAUSE
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BEAT_W-1:0]  beat_d;
    logic               tick_d, done_d;
    logic               count_en;
    logic               song_end;
    logic               rev;

`ifdef REVERSE_PLAY_EN
    assign rev = dir;
`else
    assign rev = 1'b0;
`endif

    // Song end is the last beat when counting up, beat 0 when counting down.
    assign song_end = rev ? (ibeatNum == '0) : (ibeatNum == BEAT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            ibeatNum  <= '0;
            beat_tick <= 1'b0;
            playing   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            ibeatNum  <= beat_d;
            beat_tick <= tick_d;
            playing   <= (state_d == ST_PLAY);
            done      <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        beat_d   = ibeatNum;
        tick_d   = 1'b0;
        done_d   = 1'b0;
        count_en = 1'b0;

        case (state_q)
            ST_IDLE: begin
                div_d  = '0;
                beat_d = '0;
                if (play && !stop) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                    beat_d  = '0;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else begin
                    count_en = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                    beat_d  = '0;
                end else if (play && !pause) begin
                    // Resume edge counts, so a beat held at the wrap point advances here.
                    state_d  = ST_PLAY;
                    count_en = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
                beat_d  = '0;
            end
        endcase

        if (count_en) begin
            if (div_q != DIV_MAX) begin
                div_d = div_q + 1'b1;
            end else begin
                div_d = '0;
                if (!song_end) begin
                    beat_d = rev ? (ibeatNum - 1'b1) : (ibeatNum + 1'b1);
                    tick_d = 1'b1;
                end else if (loop_en) begin
                    beat_d = rev ? BEAT_LAST : '0;
                    tick_d = 1'b1;
                end else begin
                    beat_d  = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_beat_sequencer.sv
// Scoreboard bench for beat_sequencer (BEAT_DIV=4, BEAT_LEN=8): expected outputs are queued per cycle.
module tb_beat_sequencer;

    localparam int unsigned DIV = 4;
    localparam int unsigned LEN = 8;

    typedef struct {
        int cyc;
        int beat;
        bit tick;
        bit done;
        bit play;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        play = 1'b0;
    logic        pause = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
`ifdef REVERSE_PLAY_EN
    logic        dir = 1'b0;
`endif
    logic [11:0] ibeatNum;
    logic        beat_tick;
    logic        playing;
    logic        done;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    beat_sequencer #(.BEAT_DIV(DIV), .BEAT_LEN(LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .play      (play),
        .pause     (pause),
        .stop      (stop),
`ifdef REVERSE_PLAY_EN
        .dir       (dir),
`endif
        .loop_en   (loop_en),
        .ibeatNum  (ibeatNum),
        .beat_tick (beat_tick),
        .playing   (playing),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    function automatic void push(input int c, input int b, input bit t, input bit d, input bit p);
        exp_t e;
        e.cyc = c; e.beat = b; e.tick = t; e.done = d; e.play = p;
        exp_q.push_back(e);
    endfunction

    // Uninterrupted looping playback k cycles after the play edge.
    function automatic void push_run(input int p, input int k);
        push(p + k, (k / DIV) % LEN, (k > 0) && (k % DIV == 0), 1'b0, 1'b1);
    endfunction

    function automatic void push_idle(input int c);
        push(c, 0, 1'b0, 1'b0, 1'b0);
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk($sformatf("c%0d.beat", e.cyc), 32'(ibeatNum), 32'(e.beat));
            chk($sformatf("c%0d.tick", e.cyc), 32'(beat_tick), 32'(e.tick));
            chk($sformatf("c%0d.done", e.cyc), 32'(done), 32'(e.done));
            chk($sformatf("c%0d.playing", e.cyc), 32'(playing), 32'(e.play));
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Drive the given commands so they are sampled on edge t.
    task automatic fire(input int t, input bit pl, input bit pa, input bit st);
        wait_cyc(t - 1);
        play = pl; pause = pa; stop = st;
        @(negedge clk);
        play = 1'b0; pause = 1'b0; stop = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".beat"}, 32'(ibeatNum), 32'd0);
        chk({tag, ".tick"}, 32'(beat_tick), 32'd0);
        chk({tag, ".playing"}, 32'(playing), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle_after_reset");

        // Non-looped song to completion.
        loop_en = 1'b0;
        p = cyc + 1;
        for (int k = 0; k <= 34; k++) begin
            if (k < 32) push(p + k, k / DIV, (k > 0) && (k % DIV == 0), 1'b0, 1'b1);
            else        push(p + k, 0, 1'b0, (k == 32), 1'b0);
        end
        fire(p, 1, 0, 0);
        drain();

        // Looped song wraps 7 -> 0 with a tick, then stop.
        loop_en = 1'b1;
        @(negedge clk);
        p = cyc + 1;
        for (int k = 0; k <= 41; k++) push_run(p, k);
        for (int k = 42; k <= 44; k++) push_idle(p + k);
        fire(p, 1, 0, 0);
        fire(p + 42, 0, 0, 1);
        drain();

        // Pause mid-beat then resume without losing the partial beat.
        @(negedge clk);
        p = cyc + 1;
        for (int k = 0; k <= 5; k++) push_run(p, k);
        for (int k = 6; k <= 19; k++) push(p + k, 1, 1'b0, 1'b0, 1'b0);
        for (int k = 20; k <= 21; k++) push(p + k, 1, 1'b0, 1'b0, 1'b1);
        for (int k = 22; k <= 35; k++) push(p + k, 2 + (k - 22) / DIV, (k - 22) % DIV == 0, 1'b0, 1'b1);
        for (int k = 36; k <= 38; k++) push_idle(p + k);
        fire(p, 1, 0, 0);
        fire(p + 6, 0, 1, 0);
        fire(p + 20, 1, 0, 0);
        fire(p + 36, 0, 0, 1);
        drain();

        // Stop and pause together on the wrap edge at beat 5.
        @(negedge clk);
        p = cyc + 1;
        for (int k = 0; k <= 23; k++) push_run(p, k);
        for (int k = 24; k <= 27; k++) push_idle(p + k);
        fire(p, 1, 0, 0);
        fire(p + 24, 0, 1, 1);
        drain();

        // Pause on a wrap edge suppresses the advance; resume advances immediately; stop from PAUSE.
        @(negedge clk);
        p = cyc + 1;
        for (int k = 0; k <= 3; k++) push(p + k, 0, 1'b0, 1'b0, 1'b1);
        for (int k = 4; k <= 9; k++) push(p + k, 0, 1'b0, 1'b0, 1'b0);
        for (int k = 10; k <= 15; k++) push(p + k, 1 + (k - 10) / DIV, (k - 10) % DIV == 0, 1'b0, 1'b1);
        for (int k = 16; k <= 17; k++) push(p + k, 2, 1'b0, 1'b0, 1'b0);
        for (int k = 18; k <= 20; k++) push_idle(p + k);
        fire(p, 1, 0, 0);
        fire(p + 4, 0, 1, 0);
        fire(p + 10, 1, 0, 0);
        fire(p + 16, 0, 1, 0);
        fire(p + 18, 0, 0, 1);
        drain();

        // Asynchronous reset between edges at beat 3, then restart from beat 0.
        loop_en = 1'b0;
        @(negedge clk);
        p = cyc + 1;
        for (int k = 0; k <= 13; k++) push_run(p, k);
        fire(p, 1, 0, 0);
        wait_cyc(p + 13);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("post_reset_idle");
        p = cyc + 1;
        for (int k = 0; k <= 9; k++) push_run(p, k);
        for (int k = 10; k <= 11; k++) push_idle(p + k);
        fire(p, 1, 0, 0);
        fire(p + 10, 0, 0, 1);
        drain();

`ifdef REVERSE_PLAY_EN
        // Reverse with loop: 0 -> 7 -> 6, then forward again from 6.
        loop_en = 1'b1;
        dir = 1'b1;
        @(negedge clk);
        p = cyc + 1;
        for (int k = 0; k <= 17; k++) begin
            int b;
            b = (k < 4) ? 0 : (k < 8) ? 7 : (k < 12) ? 6 : (k < 16) ? 7 : 0;
            push(p + k, b, (k > 0) && (k % DIV == 0), 1'b0, 1'b1);
        end
        for (int k = 18; k <= 19; k++) push_idle(p + k);
        fire(p, 1, 0, 0);
        wait_cyc(p + 9);
        dir = 1'b0;
        fire(p + 18, 0, 0, 1);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
